// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state and owner encodings.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant decision. Defining MEM_ARB_RR_EN selects round-robin on a tie;
// otherwise the data port has fixed priority.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_gnt,
  output owner_e owner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    owner = OwnI;
    if (i_req && d_req) begin
      owner = (last_gnt == OwnI) ? OwnD : OwnI;
    end else if (d_req) begin
      owner = OwnD;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    owner = OwnI;
    if (d_req) begin
      owner = OwnD;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port fixed-latency memory between instruction fetch and data load/store.
// Arbitration policy comes from mem_arbiter_pick (round-robin when MEM_ARB_RR_EN is defined).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_adr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_d
);

  state_e           state;
  owner_e           gnt_q;  // latched owner; doubles as last_gnt for round-robin
  owner_e           pick;
  logic [CNT_W-1:0] cnt;
  logic             we_q;

  mem_arbiter_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_gnt (gnt_q),
    .owner    (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      gnt_q     <= OwnI;
      cnt       <= '0;
      we_q      <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (i_req || d_req) begin
            gnt_q     <= pick;
            mem_adr   <= (pick == OwnD) ? d_adr : i_adr;
            mem_wdata <= (pick == OwnD) ? d_wdata : '0;
            we_q      <= (pick == OwnD) && d_we;
            cnt       <= CNT_W'(MEM_LAT - 1);
            state     <= StAccess;
          end
        end
        StAccess: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!we_q) begin
              if (gnt_q == OwnD) d_rdata <= mem_rdata;
              else               i_rdata <= mem_rdata;
            end
            state <= StResp;
          end
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Strobes and acks decode only reset-cleared state, so they drop the moment rst falls.
  assign mem_read  = (state == StAccess) && !we_q;
  assign mem_write = (state == StAccess) && we_q && (cnt == '0);
  assign busy      = (state != StIdle);
  assign i_ack     = (state == StResp) && (gnt_q == OwnI);
  assign d_ack     = (state == StResp) && (gnt_q == OwnD);
  assign gnt_d     = (gnt_q == OwnD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions queued at drive time, checked on ack.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_adr, d_adr, d_wdata;
  logic        i_ack, d_ack, mem_read, mem_write, busy, gnt_d;
  logic [31:0] i_rdata, d_rdata, mem_adr, mem_wdata, mem_rdata;

  logic        l1_d_req;
  logic [31:0] l1_d_adr;
  logic        l1_i_ack, l1_d_ack, l1_mem_read, l1_mem_write, l1_busy, l1_gnt_d;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_adr, l1_mem_wdata, l1_mem_rdata;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  assign mem_rdata    = mem[mem_adr[9:2]];
  assign l1_mem_rdata = mem[l1_mem_adr[9:2]];

  always @(posedge clk) if (mem_write) mem[mem_adr[9:2]] <= mem_wdata;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_d(gnt_d)
  );

  mem_arbiter #(.MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .i_req(1'b0), .i_adr(32'h0), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_we(1'b0), .d_adr(l1_d_adr), .d_wdata(32'h0),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_adr(l1_mem_adr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
    .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata), .busy(l1_busy), .gnt_d(l1_gnt_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          own_d;
    bit          we;
    logic [31:0] adr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_t;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  logic [31:0] i_rdata_m = '0;
  logic [31:0] d_rdata_m = '0;

  task automatic push(input bit own_d, input bit we, input logic [31:0] adr,
                      input logic [31:0] wdata);
    txn_t t;
    t.own_d = own_d;
    t.we    = we;
    t.adr   = adr;
    t.data  = we ? wdata : mem[adr[9:2]];
    exp_q.push_back(t);
  endtask

  // Memory-side and ack-side monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_read || mem_write) begin
        if (exp_q.size() == 0) begin
          check_eq("mem_strobe_unexpected", {mem_read, mem_write}, 0);
        end else begin
          check_eq("mem_adr", mem_adr, exp_q[0].adr);
          check_eq("mem_read_vs_we", mem_read, !exp_q[0].we);
          if (mem_write) check_eq("mem_wdata", mem_wdata, exp_q[0].data);
        end
        if (mem_read) rd_cyc++;
        if (mem_write) wr_cyc++;
      end
      if (i_ack || d_ack) begin
        check_eq("ack_onehot", i_ack & d_ack, 0);
        if (exp_q.size() == 0) begin
          check_eq("ack_unexpected", {i_ack, d_ack}, 0);
        end else begin
          mon_t = exp_q.pop_front();
          check_eq("ack_owner", d_ack, mon_t.own_d);
          check_eq("gnt_d", gnt_d, mon_t.own_d);
          check_eq("read_cycles", rd_cyc, mon_t.we ? 0 : LAT);
          check_eq("write_pulses", wr_cyc, mon_t.we ? 1 : 0);
          if (!mon_t.we) begin
            if (mon_t.own_d) d_rdata_m = mon_t.data;
            else             i_rdata_m = mon_t.data;
          end
          check_eq("i_rdata", i_rdata, i_rdata_m);
          check_eq("d_rdata", d_rdata, d_rdata_m);
        end
        rd_cyc = 0;
        wr_cyc = 0;
      end
    end
  end

  // One isolated transaction from idle; checks ack arrives MEM_LAT+1 cycles after the grant edge.
  task automatic single(input bit own_d, input bit we, input logic [31:0] adr,
                        input logic [31:0] wdata, input string tag);
    int lat;
    lat = 99;
    push(own_d, we, adr, wdata);
    @(posedge clk); #1;
    if (own_d) begin d_req = 1'b1; d_we = we; d_adr = adr; d_wdata = wdata; end
    else begin i_req = 1'b1; i_adr = adr; end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (own_d ? d_ack : i_ack) begin lat = c; break; end
    end
    check_eq({tag, "_latency"}, lat, LAT + 1);
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_d(output int cyc, output int idle);
    cyc  = 0;
    idle = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cyc++;
      if (!busy) idle++;
      if (d_ack) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, b, n, lat, reads;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[4]  = 32'h2002_000A;
    mem[8]  = 32'hA5A5_0008;
    mem[9]  = 32'h900D_0009;
    mem[12] = 32'h600D_000C;
    rst = 1'b0;
    i_req = 1'b0; i_adr = '0; d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdata = '0;
    l1_d_req = 1'b0; l1_d_adr = '0;
    #1;
    check_eq("rst_outputs", {i_ack, d_ack, mem_read, mem_write, busy, gnt_d}, 0);
    check_eq("rst_mem_adr", mem_adr, 0);
    check_eq("rst_rdata", {i_rdata, d_rdata}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Instruction read, then data write.
    single(1'b0, 1'b0, 32'h10, 32'h0, "t1_iread");
    single(1'b1, 1'b1, 32'h3E8, 32'h5, "t2_dwrite");
    check_eq("t2_mem_written", mem[250], 32'h5);

    // Continuous data requests: 4-cycle period with one idle cycle between transactions.
    repeat (3) push(1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h20;
    wait_d(c, b);
    wait_d(c, b);
    check_eq("t4_period", c, LAT + 2);
    check_eq("t4_idle", b, 1);
    wait_d(c, b);
    check_eq("t4_period2", c, LAT + 2);
    d_req = 1'b0;
    @(posedge clk);

    // Reset during the write cycle of a data store.
    push(1'b1, 1'b1, 32'h40, 32'h77);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h40; d_wdata = 32'h77;
    @(posedge clk);
    @(posedge clk); #2;
    check_eq("t5_write_before_rst", {mem_write, busy}, 2'b11);
    #1 rst = 1'b0;
    #1;
    check_eq("t5_async_drop", {mem_write, mem_read, busy, i_ack, d_ack, gnt_d}, 0);
    exp_q.delete();
    rd_cyc = 0; wr_cyc = 0; i_rdata_m = '0; d_rdata_m = '0;
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    single(1'b0, 1'b0, 32'h10, 32'h0, "t5_after_rst");

    // Both requesters held for four transactions; last grant was instruction.
`ifdef MEM_ARB_RR_EN
    push(1'b1, 1'b0, 32'h20, 0); push(1'b0, 1'b0, 32'h24, 0);
    push(1'b1, 1'b0, 32'h20, 0); push(1'b0, 1'b0, 32'h24, 0);
`else
    repeat (4) push(1'b1, 1'b0, 32'h20, 0);
`endif
    @(posedge clk); #1;
    i_req = 1'b1; i_adr = 32'h24; d_req = 1'b1; d_we = 1'b0; d_adr = 32'h20;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) n++;
      if (n == 4) break;
    end
    check_eq("t3_ack_count", n, 4);
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);

    // MEM_LAT=1 instance: single data read.
    @(posedge clk); #1;
    l1_d_req = 1'b1; l1_d_adr = 32'h30;
    lat = 99;
    reads = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (l1_mem_read) reads++;
      if (l1_d_ack) begin lat = k; break; end
    end
    check_eq("t6_latency", lat, 2);
    check_eq("t6_read_cycles", reads, 1);
    check_eq("t6_rdata", l1_d_rdata, 32'h600D_000C);
    l1_d_req = 1'b0;

    repeat (5) @(posedge clk);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
